// File: rtl/cva6_ypb_obi_bridge.sv
// cva6_ypb_obi_bridge
//
// Registered YPB-to-OBI bridge with NumChannels independent lanes. Each lane
// has a one-entry request slice, a credit count that bounds outstanding OBI
// requests, and a response FIFO. Because of the credit scheme the bridge can
// hold OBI rready high and still never drop a response.
//
// Ports (per-lane buses are packed [NumChannels-1:0][W-1:0]):
//   clk_i, rst_i                     clock, asynchronous active-high reset
//   ypb_preq_i / ypb_paddr_i / ypb_we_i / ypb_be_i / ypb_wdata_i / ypb_aid_i
//                                    YPB request and payload
//   ypb_pgnt_o                       YPB request accepted
//   ypb_rvalid_o / ypb_rdata_o / ypb_rid_o / ypb_err_o, ypb_rready_i
//                                    YPB response channel
//   obi_req_o, obi_reqpar_o, obi_addr_o / obi_we_o / obi_be_o / obi_wdata_o /
//   obi_aid_o, obi_gnt_i, obi_gntpar_i
//                                    OBI A-channel
//   obi_rvalid_i, obi_rvalidpar_i, obi_rdata_i / obi_rid_i / obi_err_i,
//   obi_rready_o, obi_rreadypar_o    OBI R-channel
//   idle_o                           lane empty and nothing in flight
//   proto_err_o                      sticky: response with nothing outstanding
//   par_err_o                        sticky parity error on gnt/rvalid
//
// Optional feature macro: CVA6_YPB_OBI_BRIDGE_PARITY_CHK_EN enables checking
// of obi_gntpar_i / obi_rvalidpar_i. Without it par_err_o is tied to 0.

module cva6_ypb_obi_bridge #(
  parameter int NumChannels = 4,
  parameter int AddrWidth   = 64,
  parameter int DataWidth   = 64,
  parameter int IdWidth     = 4,
  parameter int RspDepth    = 4
) (
  input  logic                                    clk_i,
  input  logic                                    rst_i,
  input  logic [NumChannels-1:0]                  ypb_preq_i,
  input  logic [NumChannels-1:0][AddrWidth-1:0]   ypb_paddr_i,
  input  logic [NumChannels-1:0]                  ypb_we_i,
  input  logic [NumChannels-1:0][DataWidth/8-1:0] ypb_be_i,
  input  logic [NumChannels-1:0][DataWidth-1:0]   ypb_wdata_i,
  input  logic [NumChannels-1:0][IdWidth-1:0]     ypb_aid_i,
  output logic [NumChannels-1:0]                  ypb_pgnt_o,
  output logic [NumChannels-1:0]                  ypb_rvalid_o,
  output logic [NumChannels-1:0][DataWidth-1:0]   ypb_rdata_o,
  output logic [NumChannels-1:0][IdWidth-1:0]     ypb_rid_o,
  output logic [NumChannels-1:0]                  ypb_err_o,
  input  logic [NumChannels-1:0]                  ypb_rready_i,
  output logic [NumChannels-1:0]                  obi_req_o,
  output logic [NumChannels-1:0]                  obi_reqpar_o,
  output logic [NumChannels-1:0][AddrWidth-1:0]   obi_addr_o,
  output logic [NumChannels-1:0]                  obi_we_o,
  output logic [NumChannels-1:0][DataWidth/8-1:0] obi_be_o,
  output logic [NumChannels-1:0][DataWidth-1:0]   obi_wdata_o,
  output logic [NumChannels-1:0][IdWidth-1:0]     obi_aid_o,
  input  logic [NumChannels-1:0]                  obi_gnt_i,
  input  logic [NumChannels-1:0]                  obi_gntpar_i,
  input  logic [NumChannels-1:0]                  obi_rvalid_i,
  input  logic [NumChannels-1:0]                  obi_rvalidpar_i,
  input  logic [NumChannels-1:0][DataWidth-1:0]   obi_rdata_i,
  input  logic [NumChannels-1:0][IdWidth-1:0]     obi_rid_i,
  input  logic [NumChannels-1:0]                  obi_err_i,
  output logic [NumChannels-1:0]                  obi_rready_o,
  output logic [NumChannels-1:0]                  obi_rreadypar_o,
  output logic [NumChannels-1:0]                  idle_o,
  output logic [NumChannels-1:0]                  proto_err_o,
  output logic [NumChannels-1:0]                  par_err_o
);

  localparam int PtrW  = $clog2(RspDepth);
  localparam int CntW  = $clog2(RspDepth) + 1;
  localparam int FifoW = DataWidth + IdWidth + 1;
  localparam logic [CntW-1:0] DepthCnt = CntW'(RspDepth);

  // The FIFO always has room for every outstanding response, so rready only
  // drops while the bridge is held in reset.
  assign obi_rready_o    = {NumChannels{!rst_i}};
  assign obi_rreadypar_o = ~obi_rready_o;

`ifndef CVA6_YPB_OBI_BRIDGE_PARITY_CHK_EN
  logic unused_parity;
  assign unused_parity = ^{obi_gntpar_i, obi_rvalidpar_i};
`endif

  for (genvar c = 0; c < NumChannels; c++) begin : g_lane
    logic                   slot_v;
    logic [AddrWidth-1:0]   slot_addr;
    logic                   slot_we;
    logic [DataWidth/8-1:0] slot_be;
    logic [DataWidth-1:0]   slot_wdata;
    logic [IdWidth-1:0]     slot_aid;
    logic [CntW-1:0]        outstanding;
    logic [CntW-1:0]        fifo_count;
    logic [CntW-1:0]        credit;
    logic [PtrW-1:0]        wr_ptr;
    logic [PtrW-1:0]        rd_ptr;
    logic [FifoW-1:0]       fifo_mem [RspDepth];
    logic [FifoW-1:0]       head;
    logic                   req;
    logic                   fire;
    logic                   grant;
    logic                   accept;
    logic                   push;
    logic                   pop;
    logic                   proto_err;

    // Credit counts both in-flight requests and responses still parked in the
    // FIFO; only this lane's own grant consumes it, so a raised req is stable.
    assign credit = DepthCnt - outstanding - fifo_count;
    assign req    = slot_v && (credit != '0);
    assign fire   = req && obi_gnt_i[c];
    assign grant  = !rst_i && (!slot_v || fire);
    assign accept = ypb_preq_i[c] && grant;
    assign push   = obi_rvalid_i[c] && (outstanding != '0);
    assign pop    = (fifo_count != '0) && ypb_rready_i[c];
    assign head   = (fifo_count != '0) ? fifo_mem[rd_ptr] : '0;

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        slot_v     <= 1'b0;
        slot_addr  <= '0;
        slot_we    <= 1'b0;
        slot_be    <= '0;
        slot_wdata <= '0;
        slot_aid   <= '0;
      end else if (accept) begin
        slot_v     <= 1'b1;
        slot_addr  <= ypb_paddr_i[c];
        slot_we    <= ypb_we_i[c];
        slot_be    <= ypb_be_i[c];
        slot_wdata <= ypb_wdata_i[c];
        slot_aid   <= ypb_aid_i[c];
      end else if (fire) begin
        slot_v <= 1'b0;
      end
    end

    // A response arriving with nothing outstanding is dropped and flagged.
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        outstanding <= '0;
        fifo_count  <= '0;
        wr_ptr      <= '0;
        rd_ptr      <= '0;
        proto_err   <= 1'b0;
      end else begin
        case ({fire, push})
          2'b10:   outstanding <= outstanding + 1'b1;
          2'b01:   outstanding <= outstanding - 1'b1;
          default: outstanding <= outstanding;
        endcase
        case ({push, pop})
          2'b10:   fifo_count <= fifo_count + 1'b1;
          2'b01:   fifo_count <= fifo_count - 1'b1;
          default: fifo_count <= fifo_count;
        endcase
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        if (obi_rvalid_i[c] && (outstanding == '0)) proto_err <= 1'b1;
      end
    end

    always_ff @(posedge clk_i) begin
      if (push) fifo_mem[wr_ptr] <= {obi_rdata_i[c], obi_rid_i[c], obi_err_i[c]};
    end

`ifdef CVA6_YPB_OBI_BRIDGE_PARITY_CHK_EN
    // Parity lines carry the inverse of their signal; equality is an error.
    logic par_err;
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        par_err <= 1'b0;
      end else if ((obi_gntpar_i[c] == obi_gnt_i[c]) ||
                   (obi_rvalidpar_i[c] == obi_rvalid_i[c])) begin
        par_err <= 1'b1;
      end
    end
    assign par_err_o[c] = par_err;
`else
    assign par_err_o[c] = 1'b0;
`endif

    assign ypb_pgnt_o[c]   = grant;
    assign ypb_rvalid_o[c] = (fifo_count != '0);
    assign {ypb_rdata_o[c], ypb_rid_o[c], ypb_err_o[c]} = head;
    assign obi_req_o[c]    = req;
    assign obi_reqpar_o[c] = !req;
    assign obi_addr_o[c]   = slot_addr;
    assign obi_we_o[c]     = slot_we;
    assign obi_be_o[c]     = slot_be;
    assign obi_wdata_o[c]  = slot_wdata;
    assign obi_aid_o[c]    = slot_aid;
    assign idle_o[c]       = !slot_v && (outstanding == '0) && (fifo_count == '0);
    assign proto_err_o[c]  = proto_err;
  end

endmodule

// File: tb/tb_cva6_ypb_obi_bridge.sv
// tb_cva6_ypb_obi_bridge
//
// Self-checking bench for cva6_ypb_obi_bridge with default parameters
// (4 lanes, 64-bit address/data, 4-bit ids, depth 4). Directed scenarios plus
// a randomized run checked against a transaction-level queue model.

module tb_cva6_ypb_obi_bridge;

  localparam int N     = 4;
  localparam int AW    = 64;
  localparam int DW    = 64;
  localparam int IW    = 4;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic [AW-1:0]   addr;
    logic            we;
    logic [DW/8-1:0] be;
    logic [DW-1:0]   wdata;
    logic [IW-1:0]   aid;
  } req_t;

  typedef struct packed {
    logic [DW-1:0] rdata;
    logic [IW-1:0] rid;
    logic          err;
  } rsp_t;

  logic clk_i = 1'b0;
  logic rst_i;
  logic [N-1:0]            ypb_preq, ypb_we, ypb_pgnt, ypb_rvalid, ypb_err, ypb_rready;
  logic [N-1:0][AW-1:0]    ypb_paddr, obi_addr;
  logic [N-1:0][DW/8-1:0]  ypb_be, obi_be;
  logic [N-1:0][DW-1:0]    ypb_wdata, ypb_rdata, obi_wdata, obi_rdata;
  logic [N-1:0][IW-1:0]    ypb_aid, ypb_rid, obi_aid, obi_rid;
  logic [N-1:0]            obi_req, obi_reqpar, obi_we, obi_gnt, obi_gntpar;
  logic [N-1:0]            obi_rvalid, obi_rvalidpar, obi_err, obi_rready, obi_rreadypar;
  logic [N-1:0]            idle, proto_err, par_err;
  logic [N-1:0]            gnt_flip, rvalid_flip;

  int checks = 0;
  int errors = 0;

  req_t slot_q [N][$];
  rsp_t rsp_q  [N][$];
  int   outst  [N];

  // Parity inputs normally carry the correct inverted value; flips inject errors.
  assign obi_gntpar    = ~obi_gnt ^ gnt_flip;
  assign obi_rvalidpar = ~obi_rvalid ^ rvalid_flip;

  always #5 clk_i = ~clk_i;

  cva6_ypb_obi_bridge #(
    .NumChannels(N), .AddrWidth(AW), .DataWidth(DW), .IdWidth(IW), .RspDepth(DEPTH)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .ypb_preq_i(ypb_preq), .ypb_paddr_i(ypb_paddr), .ypb_we_i(ypb_we), .ypb_be_i(ypb_be),
    .ypb_wdata_i(ypb_wdata), .ypb_aid_i(ypb_aid), .ypb_pgnt_o(ypb_pgnt),
    .ypb_rvalid_o(ypb_rvalid), .ypb_rdata_o(ypb_rdata), .ypb_rid_o(ypb_rid),
    .ypb_err_o(ypb_err), .ypb_rready_i(ypb_rready),
    .obi_req_o(obi_req), .obi_reqpar_o(obi_reqpar), .obi_addr_o(obi_addr), .obi_we_o(obi_we),
    .obi_be_o(obi_be), .obi_wdata_o(obi_wdata), .obi_aid_o(obi_aid),
    .obi_gnt_i(obi_gnt), .obi_gntpar_i(obi_gntpar),
    .obi_rvalid_i(obi_rvalid), .obi_rvalidpar_i(obi_rvalidpar),
    .obi_rdata_i(obi_rdata), .obi_rid_i(obi_rid), .obi_err_i(obi_err),
    .obi_rready_o(obi_rready), .obi_rreadypar_o(obi_rreadypar),
    .idle_o(idle), .proto_err_o(proto_err), .par_err_o(par_err)
  );

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear_inputs;
    ypb_preq = '0; ypb_paddr = '0; ypb_we = '0; ypb_be = '0; ypb_wdata = '0; ypb_aid = '0;
    ypb_rready = '1;
    obi_gnt = '0; obi_rvalid = '0; obi_rdata = '0; obi_rid = '0; obi_err = '0;
    gnt_flip = '0; rvalid_flip = '0;
  endtask

  task automatic do_reset;
    rst_i = 1'b1;
    clear_inputs();
    tick();
    tick();
    rst_i = 1'b0;
  endtask

  task automatic test_reset;
    rst_i = 1'b1;
    clear_inputs();
    #2;
    checks++; if (ypb_pgnt !== 4'b0000) begin errors++; $display("[TB] FAIL reset_pgnt: got %b expected 0000", ypb_pgnt); end
    checks++; if (obi_req !== 4'b0000) begin errors++; $display("[TB] FAIL reset_req: got %b expected 0000", obi_req); end
    checks++; if (obi_reqpar !== 4'b1111) begin errors++; $display("[TB] FAIL reset_reqpar: got %b expected 1111", obi_reqpar); end
    checks++; if (obi_rready !== 4'b0000) begin errors++; $display("[TB] FAIL reset_rready: got %b expected 0000", obi_rready); end
    checks++; if (obi_rreadypar !== 4'b1111) begin errors++; $display("[TB] FAIL reset_rreadypar: got %b expected 1111", obi_rreadypar); end
    checks++; if (ypb_rvalid !== 4'b0000) begin errors++; $display("[TB] FAIL reset_rvalid: got %b expected 0000", ypb_rvalid); end
    checks++; if ((proto_err | par_err) !== 4'b0000) begin errors++; $display("[TB] FAIL reset_errs: got %b/%b expected 0", proto_err, par_err); end
    tick();
    tick();
    rst_i = 1'b0;
    #2;
    checks++; if (idle !== 4'b1111) begin errors++; $display("[TB] FAIL reset_idle: got %b expected 1111", idle); end
    checks++; if (obi_rready !== 4'b1111) begin errors++; $display("[TB] FAIL release_rready: got %b expected 1111", obi_rready); end
    checks++; if (ypb_pgnt !== 4'b1111) begin errors++; $display("[TB] FAIL release_pgnt: got %b expected 1111", ypb_pgnt); end
  endtask

  task automatic test_single_read;
    do_reset();
    ypb_preq[0] = 1'b1; ypb_paddr[0] = 64'h8000_0000; ypb_aid[0] = 4'd3; obi_gnt[0] = 1'b1;
    #2;
    checks++; if (obi_req[0] !== 1'b0) begin errors++; $display("[TB] FAIL single_req_early: got %b expected 0", obi_req[0]); end
    tick();
    ypb_preq[0] = 1'b0;
    #2;
    checks++; if (obi_req[0] !== 1'b1) begin errors++; $display("[TB] FAIL single_req: got %b expected 1", obi_req[0]); end
    checks++; if (obi_addr[0] !== 64'h8000_0000) begin errors++; $display("[TB] FAIL single_addr: got %h expected 80000000", obi_addr[0]); end
    checks++; if (obi_aid[0] !== 4'd3) begin errors++; $display("[TB] FAIL single_aid: got %h expected 3", obi_aid[0]); end
    tick();
    obi_rvalid[0] = 1'b1; obi_rdata[0] = 64'hDEAD_BEEF; obi_rid[0] = 4'd3;
    #2;
    checks++; if (ypb_rvalid[0] !== 1'b0) begin errors++; $display("[TB] FAIL single_rvalid_early: got %b expected 0", ypb_rvalid[0]); end
    tick();
    obi_rvalid[0] = 1'b0;
    #2;
    checks++; if (ypb_rvalid[0] !== 1'b1) begin errors++; $display("[TB] FAIL single_rvalid: got %b expected 1", ypb_rvalid[0]); end
    checks++; if (ypb_rdata[0] !== 64'hDEAD_BEEF) begin errors++; $display("[TB] FAIL single_rdata: got %h expected deadbeef", ypb_rdata[0]); end
    checks++; if (ypb_rid[0] !== 4'd3) begin errors++; $display("[TB] FAIL single_rid: got %h expected 3", ypb_rid[0]); end
    tick();
    #2;
    checks++; if (idle[0] !== 1'b1) begin errors++; $display("[TB] FAIL single_idle: got %b expected 1", idle[0]); end
  endtask

  task automatic test_credit_stall;
    int accepted, grants, resps;
    do_reset();
    accepted = 0; grants = 0; resps = 0;
    ypb_rready[2] = 1'b0; obi_gnt[2] = 1'b1;
    for (int cyc = 0; cyc < 16; cyc++) begin
      ypb_preq[2]   = (accepted < 6);
      ypb_paddr[2]  = 64'h1000 + 64'(accepted);
      obi_rvalid[2] = (grants > resps);
      obi_rid[2]    = IW'(resps);
      #2;
      if (ypb_preq[2] && ypb_pgnt[2]) accepted++;
      if (obi_req[2] && obi_gnt[2]) grants++;
      if (obi_rvalid[2]) resps++;
      tick();
    end
    obi_rvalid[2] = 1'b0;
    #2;
    checks++; if (grants != 4) begin errors++; $display("[TB] FAIL credit_grants: got %0d expected 4", grants); end
    checks++; if (accepted != 5) begin errors++; $display("[TB] FAIL credit_accepts: got %0d expected 5", accepted); end
    checks++; if (obi_req[2] !== 1'b0) begin errors++; $display("[TB] FAIL credit_req_low: got %b expected 0", obi_req[2]); end
    checks++; if (ypb_pgnt[2] !== 1'b0) begin errors++; $display("[TB] FAIL credit_pgnt_low: got %b expected 0", ypb_pgnt[2]); end
    checks++; if (ypb_rid[2] !== 4'd0) begin errors++; $display("[TB] FAIL credit_head_rid: got %h expected 0", ypb_rid[2]); end
    ypb_rready[2] = 1'b1;
    tick();
    ypb_rready[2] = 1'b0;
    #2;
    checks++; if (obi_req[2] !== 1'b1) begin errors++; $display("[TB] FAIL credit_fifth_req: got %b expected 1", obi_req[2]); end
    checks++; if (obi_addr[2] !== 64'h1004) begin errors++; $display("[TB] FAIL credit_fifth_addr: got %h expected 1004", obi_addr[2]); end
    checks++; if (ypb_rid[2] !== 4'd1) begin errors++; $display("[TB] FAIL credit_next_rid: got %h expected 1", ypb_rid[2]); end
    tick();
    #2;
    checks++; if (obi_req[2] !== 1'b0) begin errors++; $display("[TB] FAIL credit_sixth_held: got %b expected 0", obi_req[2]); end
  endtask

  task automatic test_backpressure;
    do_reset();
    ypb_preq[3] = 1'b1; ypb_paddr[3] = 64'hA000; ypb_aid[3] = 4'd5; obi_gnt[3] = 1'b0;
    tick();
    ypb_paddr[3] = 64'hB000; ypb_aid[3] = 4'd6;
    for (int cyc = 0; cyc < 3; cyc++) begin
      #2;
      checks++; if (obi_req[3] !== 1'b1) begin errors++; $display("[TB] FAIL bp_req: got %b expected 1", obi_req[3]); end
      checks++; if (obi_addr[3] !== 64'hA000 || obi_aid[3] !== 4'd5) begin errors++; $display("[TB] FAIL bp_payload: got %h/%h expected a000/5", obi_addr[3], obi_aid[3]); end
      checks++; if (ypb_pgnt[3] !== 1'b0) begin errors++; $display("[TB] FAIL bp_pgnt: got %b expected 0", ypb_pgnt[3]); end
      tick();
    end
    obi_gnt[3] = 1'b1;
    #2;
    checks++; if (ypb_pgnt[3] !== 1'b1) begin errors++; $display("[TB] FAIL bp_release_pgnt: got %b expected 1", ypb_pgnt[3]); end
    tick();
    ypb_preq[3] = 1'b0;
    #2;
    checks++; if (obi_req[3] !== 1'b1 || obi_addr[3] !== 64'hB000 || obi_aid[3] !== 4'd6) begin errors++; $display("[TB] FAIL bp_second: got %b/%h/%h expected 1/b000/6", obi_req[3], obi_addr[3], obi_aid[3]); end
  endtask

  task automatic test_stray_response;
    do_reset();
    obi_rvalid[1] = 1'b1; obi_rdata[1] = 64'h1234; obi_rid[1] = 4'd9;
    tick();
    obi_rvalid[1] = 1'b0;
    #2;
    checks++; if (ypb_rvalid[1] !== 1'b0) begin errors++; $display("[TB] FAIL stray_rvalid: got %b expected 0", ypb_rvalid[1]); end
    checks++; if (proto_err !== 4'b0010) begin errors++; $display("[TB] FAIL stray_proto: got %b expected 0010", proto_err); end
    repeat (3) tick();
    checks++; if (proto_err[1] !== 1'b1 || idle[1] !== 1'b1) begin errors++; $display("[TB] FAIL stray_sticky: got %b/%b expected 1/1", proto_err[1], idle[1]); end
  endtask

  task automatic test_parity;
    logic [N-1:0] exp_par;
`ifdef CVA6_YPB_OBI_BRIDGE_PARITY_CHK_EN
    exp_par = 4'b0001;
`else
    exp_par = 4'b0000;
`endif
    do_reset();
    obi_gnt[0] = 1'b1; gnt_flip[0] = 1'b1;
    #2;
    checks++; if (par_err !== 4'b0000) begin errors++; $display("[TB] FAIL par_before: got %b expected 0000", par_err); end
    tick();
    obi_gnt[0] = 1'b0; gnt_flip[0] = 1'b0;
    #2;
    checks++; if (par_err !== exp_par) begin errors++; $display("[TB] FAIL par_flag: got %b expected %b", par_err, exp_par); end
    tick();
    checks++; if (par_err !== exp_par) begin errors++; $display("[TB] FAIL par_sticky: got %b expected %b", par_err, exp_par); end
  endtask

  task automatic test_mid_reset;
    do_reset();
    obi_gnt[0] = 1'b1; obi_gnt[1] = 1'b1;
    for (int cyc = 0; cyc < 8; cyc++) begin
      ypb_preq[0]   = 1'b1;
      ypb_paddr[0]  = 64'h2000 + 64'(cyc);
      ypb_preq[1]   = (cyc < 2);
      obi_rvalid[0] = (cyc >= 2);
      obi_rid[0]    = IW'(cyc);
      #2;
      if (cyc >= 2) begin
        checks++; if (ypb_pgnt[0] !== 1'b1 || obi_req[0] !== 1'b1) begin errors++; $display("[TB] FAIL stream_lane0 c%0d: got %b/%b expected 1/1", cyc, ypb_pgnt[0], obi_req[0]); end
      end
      tick();
    end
    #2;
    checks++; if (idle[1] !== 1'b0 || ypb_rvalid[0] !== 1'b1) begin errors++; $display("[TB] FAIL prereset_state: got idle1=%b rvalid0=%b expected 0/1", idle[1], ypb_rvalid[0]); end
    rst_i = 1'b1;
    #1;
    checks++; if (ypb_pgnt !== 4'b0 || obi_req !== 4'b0 || obi_reqpar !== 4'b1111) begin errors++; $display("[TB] FAIL midrst_req: got %b/%b/%b expected 0000/0000/1111", ypb_pgnt, obi_req, obi_reqpar); end
    checks++; if (obi_rready !== 4'b0 || obi_rreadypar !== 4'b1111 || ypb_rvalid !== 4'b0) begin errors++; $display("[TB] FAIL midrst_rsp: got %b/%b/%b expected 0000/1111/0000", obi_rready, obi_rreadypar, ypb_rvalid); end
    checks++; if (obi_addr !== '0 || ypb_rdata !== '0) begin errors++; $display("[TB] FAIL midrst_payload: got %h/%h expected 0", obi_addr, ypb_rdata); end
    clear_inputs();
    tick();
    tick();
    rst_i = 1'b0;
    #2;
    checks++; if (idle !== 4'b1111) begin errors++; $display("[TB] FAIL midrst_idle: got %b expected 1111", idle); end
    obi_rvalid[1] = 1'b1;
    tick();
    obi_rvalid[1] = 1'b0;
    #2;
    checks++; if (proto_err !== 4'b0010 || ypb_rvalid[1] !== 1'b0) begin errors++; $display("[TB] FAIL inflight_proto: got %b/%b expected 0010/0", proto_err, ypb_rvalid[1]); end
  endtask

  task automatic test_random;
    req_t got_req, new_req;
    rsp_t got_rsp, new_rsp;
    bit   exp_req, exp_fire, exp_pgnt, exp_rvalid, exp_idle;
    do_reset();
    for (int c = 0; c < N; c++) begin
      slot_q[c].delete();
      rsp_q[c].delete();
      outst[c] = 0;
    end
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int c = 0; c < N; c++) begin
        ypb_preq[c]   = 1'($urandom_range(0, 1));
        ypb_paddr[c]  = {$urandom, $urandom};
        ypb_we[c]     = 1'($urandom_range(0, 1));
        ypb_be[c]     = 8'($urandom);
        ypb_wdata[c]  = {$urandom, $urandom};
        ypb_aid[c]    = IW'($urandom);
        obi_gnt[c]    = ($urandom_range(0, 9) < 6);
        ypb_rready[c] = ($urandom_range(0, 9) < 6);
        obi_rvalid[c] = (outst[c] > 0) && ($urandom_range(0, 1) == 1);
        obi_rdata[c]  = {$urandom, $urandom};
        obi_rid[c]    = IW'($urandom);
        obi_err[c]    = 1'($urandom_range(0, 1));
      end
      #2;
      for (int c = 0; c < N; c++) begin
        exp_req    = (slot_q[c].size() == 1) && ((DEPTH - outst[c] - rsp_q[c].size()) > 0);
        exp_fire   = exp_req && obi_gnt[c];
        exp_pgnt   = (slot_q[c].size() == 0) || exp_fire;
        exp_rvalid = (rsp_q[c].size() > 0);
        exp_idle   = (slot_q[c].size() == 0) && (outst[c] == 0) && (rsp_q[c].size() == 0);
        checks++; if (obi_req[c] !== exp_req) begin errors++; $display("[TB] FAIL rnd_req c%0d l%0d: got %b expected %b", cyc, c, obi_req[c], exp_req); end
        checks++; if (ypb_pgnt[c] !== exp_pgnt) begin errors++; $display("[TB] FAIL rnd_pgnt c%0d l%0d: got %b expected %b", cyc, c, ypb_pgnt[c], exp_pgnt); end
        checks++; if (ypb_rvalid[c] !== exp_rvalid) begin errors++; $display("[TB] FAIL rnd_rvalid c%0d l%0d: got %b expected %b", cyc, c, ypb_rvalid[c], exp_rvalid); end
        checks++; if (idle[c] !== exp_idle) begin errors++; $display("[TB] FAIL rnd_idle c%0d l%0d: got %b expected %b", cyc, c, idle[c], exp_idle); end
        if (exp_req) begin
          got_req = {obi_addr[c], obi_we[c], obi_be[c], obi_wdata[c], obi_aid[c]};
          checks++; if (got_req !== slot_q[c][0]) begin errors++; $display("[TB] FAIL rnd_payload c%0d l%0d: got %h expected %h", cyc, c, got_req, slot_q[c][0]); end
        end
        if (exp_rvalid) begin
          got_rsp = {ypb_rdata[c], ypb_rid[c], ypb_err[c]};
          checks++; if (got_rsp !== rsp_q[c][0]) begin errors++; $display("[TB] FAIL rnd_rsp c%0d l%0d: got %h expected %h", cyc, c, got_rsp, rsp_q[c][0]); end
        end
        if (exp_fire) void'(slot_q[c].pop_front());
        if (ypb_preq[c] && exp_pgnt) begin
          new_req = {ypb_paddr[c], ypb_we[c], ypb_be[c], ypb_wdata[c], ypb_aid[c]};
          slot_q[c].push_back(new_req);
        end
        if (exp_rvalid && ypb_rready[c]) void'(rsp_q[c].pop_front());
        if (obi_rvalid[c]) begin
          new_rsp = {obi_rdata[c], obi_rid[c], obi_err[c]};
          rsp_q[c].push_back(new_rsp);
          outst[c]--;
        end
        if (exp_fire) outst[c]++;
      end
      tick();
    end
    checks++; if (proto_err !== 4'b0000) begin errors++; $display("[TB] FAIL rnd_proto: got %b expected 0000", proto_err); end
  endtask

  initial begin
    rst_i = 1'b1;
    clear_inputs();
    $display("[TB] starting cva6_ypb_obi_bridge bench");
    test_reset();
    test_single_read();
    test_credit_stall();
    test_backpressure();
    test_stray_response();
    test_parity();
    test_mid_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cva6_ypb_obi_bridge.md
# cva6_ypb_obi_bridge

Parametrised, registered YPB-to-OBI bridge. It replaces the per-channel combinational mapping in the cache subsystem with NumChannels independent lanes (fetch, load, store, AMO, PTW, ZCMT, and so on). Each lane has a one-entry request slice, credit-based outstanding tracking and a response FIFO. The bridge sits between the CVA6 cache or adapter ports and the OBI NoC, so OBI `rready` can stay high without ever losing a response.

## Interface
Parameters:
- NumChannels, 4, number of independent YPB/OBI lanes (1..8)
- AddrWidth, 64, physical address width
- DataWidth, 64, data width; BE width is DataWidth/8
- IdWidth, 4, aid/rid width
- RspDepth, 4, response FIFO depth per lane; also the outstanding limit (power of 2, ≥2)

Ports (per-lane buses are packed as [NumChannels-1:0][W-1:0]):
- clk_i  in  1  clock
- rst_i  in  1  asynchronous, active-high reset
- ypb_preq_i  in  N  YPB request valid
- ypb_paddr_i / ypb_we_i / ypb_be_i / ypb_wdata_i / ypb_aid_i  in  N×(AW/1/DW/8/DW/IW)  request payload
- ypb_pgnt_o  out  N  request accepted
- ypb_rvalid_o  out  N  response valid
- ypb_rdata_o / ypb_rid_o / ypb_err_o  out  N×(DW/IW/1)  response payload
- ypb_rready_i  in  N  response consumed
- obi_req_o, obi_reqpar_o  out  N  OBI request and its inverted parity
- obi_addr_o / obi_we_o / obi_be_o / obi_wdata_o / obi_aid_o  out  N×(AW/1/DW/8/DW/IW)  OBI A-channel
- obi_gnt_i, obi_gntpar_i  in  N  grant and parity
- obi_rvalid_i, obi_rvalidpar_i  in  N  response valid and parity
- obi_rdata_i / obi_rid_i / obi_err_i  in  N×(DW/IW/1)  R-channel
- obi_rready_o, obi_rreadypar_o  out  N  response ready and parity
- idle_o  out  N  lane has an empty slice, no outstanding request and an empty FIFO
- proto_err_o  out  N  sticky: response received with no outstanding request
- par_err_o  out  N  sticky parity error (see Configuration)

## Operation
All lanes are identical and independent.
- **Slice.** Holds one request; `slot_v` is its valid bit.
  - ypb_pgnt_o = !rst_i && (!slot_v || fire), where fire = obi_req_o && obi_gnt_i.
  - Accept happens on preq && pgnt: the payload is captured and slot_v is set.
  - fire without accept clears slot_v.
- **Credits.** credit = RspDepth − outstanding − fifo_count, width clog2(RspDepth)+1.
  - obi_req_o = slot_v && credit≠0.
  - Once asserted, obi_req_o and the payload stay stable until gnt. Credit cannot reach 0 while a request is pending, because only this lane's own grant consumes credit.
- **Outstanding counter.**
  - +1 on fire.
  - −1 on obi_rvalid_i when outstanding>0.
  - Both in the same cycle leaves it unchanged.
- **Response FIFO.**
  - Pushes {rdata, rid, err} on obi_rvalid_i && outstanding>0.
  - Pops on ypb_rvalid_o && ypb_rready_i.
  - No bypass path. Push and pop in the same cycle keeps the count.
  - Overflow is impossible by construction of the credit scheme.
- **Stray response.** obi_rvalid_i with outstanding==0 is dropped and sets proto_err_o.
- **OBI ready.** obi_rready_o = !rst_i. Parities: reqpar = !req, rreadypar = !rready.
- **Idle.** idle_o = !slot_v && outstanding==0 && fifo empty.

## Timing
- **Reset values** (all outputs):
  - slot_v=0, counters=0, FIFO empty.
  - ypb_pgnt_o=0 while rst_i is high.
  - obi_req_o=0, obi_reqpar_o=1, obi_rready_o=0, obi_rreadypar_o=1.
  - ypb_rvalid_o=0, payload outputs=0, idle_o=1 (after release), proto_err_o=0, par_err_o=0.
- **Request latency:** accept at cycle t → obi_req_o at t+1. Back-to-back accepts sustain 1 request/cycle while gnt=1 and credit>0.
- **Response latency:** obi_rvalid_i at t → ypb_rvalid_o at t+1.
- **Reset mid-operation:** all state is discarded immediately. In-flight OBI responses arriving after release are flagged through proto_err_o.

## Configuration
- Macro: CVA6_YPB_OBI_BRIDGE_PARITY_CHK_EN.
- **Defined:** each cycle the lane checks obi_gntpar_i==!obi_gnt_i and obi_rvalidpar_i==!obi_rvalid_i. A mismatch sets par_err_o[c] one cycle later; it is sticky until reset.
- **Undefined:** par_err_o is tied to 0 and the parity inputs are unused.

## Test plan
- **Single read, lane 0.** Stimulus: preq with paddr=0x8000_0000, aid=3, gnt=1; rvalid 2 cycles later with rdata=0xDEAD_BEEF, rid=3. Required: obi_req at t+1; ypb_rvalid one cycle after OBI rvalid with the same data and rid; idle_o returns to 1.
- **Credit stall.** Stimulus: RspDepth=4, gnt=1, ypb_rready=0, 6 requests, responses returned. Required: exactly 4 grants; obi_req held low with the 5th request pending; 5th grant only after the first YPB pop.
- **Back-pressure.** Stimulus: gnt=0 for 3 cycles. Required: obi_req and addr stable, pgnt=0, no payload change.
- **Stray response.** Stimulus: obi_rvalid with outstanding=0. Required: no ypb_rvalid; proto_err_o=1 and sticky.
- **Parity (macro defined).** Stimulus: gnt=1 with gntpar=1. Required: par_err_o=1 next cycle. With the macro undefined, par_err_o stays 0.
- **Mid-transfer reset plus lane independence.** Stimulus: lane 1 stalled with 2 outstanding, lane 0 streaming, then rst_i pulsed. Required: lane 0 is unaffected before the reset; all outputs return to reset values; idle_o=1 on every lane after release.
